// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// ----------------------------------------------------------------------------
// Shares the single on-chip feature/weight SRAM port among three bus interface
// units: imap_biu (read), wt_biu (read) and omap_biu (write).
//
// Arbitration is per session. A BIU raises its level req. From IDLE the
// arbiter takes one cycle to register a round-robin grant. The order is
// imap -> wt -> omap -> imap, starting at the rr pointer. The owner then keeps
// the port until it drops both req and vld. The pointer then moves to the BIU
// after the owner, and one IDLE cycle separates consecutive sessions.
//
// Commands pass straight through in the same cycle. A beat is owner vld & rdy.
// Read data comes back from the SRAM one cycle later. A registered tag routes
// it to the BIU that issued the read, even if the grant has moved on by then.
//
// Optional feature (macro ARB_BURST_LIMIT_EN):
//   The owner's beats are counted. After MAX_BURST beats, if any other BIU is
//   requesting, the owner is cut off (rdy=0 for that cycle) and the grant
//   rotates. The owner keeps its req and is granted again in round-robin order.
//   If no other BIU is requesting, the count restarts and the grant is held.
//   Without the macro there is no counter and MAX_BURST has no effect.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   imap_biu2arb_req/addr/vld      imap session request, read command
//   imap_biu2arb_rdy               imap command accepted
//   arb2imap_biu_data/vld          imap read return
//   wt_biu2arb_*, arb2wt_biu_*     same set for the weight BIU
//   omap_biu2arb_req/addr/data/vld omap session request, write command
//   omap_biu2arb_rdy               omap write accepted
//   arb2mem_en/we/addr/wdata       SRAM access port
//   mem2arb_rdata                  SRAM read data (1 cycle after read strobe)
//   arb_gnt                        one-hot owner {omap,wt,imap}; 0 = idle
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          imap_biu2arb_req,
    input  logic [AW-1:0] imap_biu2arb_addr,
    input  logic          imap_biu2arb_vld,
    output logic          imap_biu2arb_rdy,
    output logic [DW-1:0] arb2imap_biu_data,
    output logic          arb2imap_biu_vld,

    input  logic          wt_biu2arb_req,
    input  logic [AW-1:0] wt_biu2arb_addr,
    input  logic          wt_biu2arb_vld,
    output logic          wt_biu2arb_rdy,
    output logic [DW-1:0] arb2wt_biu_data,
    output logic          arb2wt_biu_vld,

    input  logic          omap_biu2arb_req,
    input  logic [AW-1:0] omap_biu2arb_addr,
    input  logic [DW-1:0] omap_biu2arb_data,
    input  logic          omap_biu2arb_vld,
    output logic          omap_biu2arb_rdy,

    output logic          arb2mem_en,
    output logic          arb2mem_we,
    output logic [AW-1:0] arb2mem_addr,
    output logic [DW-1:0] arb2mem_wdata,
    input  logic [DW-1:0] mem2arb_rdata,

    output logic [2:0]    arb_gnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;          // one-hot owner {omap,wt,imap}
    logic [2:0] rr_q, rr_d;            // one-hot round-robin start point
    logic       rd_vld_q, rd_vld_d;    // read return due this cycle
    logic       rd_tag_wt_q, rd_tag_wt_d;  // 1: return belongs to wt, 0: imap

    logic [2:0] req_vec;
    logic [2:0] vld_vec;
    logic [2:0] rdy_vec;
    logic       owner_req;
    logic       owner_vld;
    logic       other_req;
    logic       beat;
    logic       release_now;
    logic       preempt;

    logic [2:0] rr_mask;
    logic [2:0] req_hi;
    logic [2:0] req_cand;
    logic [2:0] pick;

    assign req_vec = {omap_biu2arb_req, wt_biu2arb_req, imap_biu2arb_req};
    assign vld_vec = {omap_biu2arb_vld, wt_biu2arb_vld, imap_biu2arb_vld};

    assign owner_req = |(gnt_q & req_vec);
    assign owner_vld = |(gnt_q & vld_vec);
    assign other_req = |(~gnt_q & req_vec);

    // Round-robin pick. First look at requesters at or above the pointer
    // (mask = all bits >= rr). If there are none, wrap around and look at all
    // requesters. The lowest set bit of the chosen group wins.
    assign rr_mask  = ~(rr_q - 3'd1);
    assign req_hi   = req_vec & rr_mask;
    assign req_cand = (req_hi != 3'b000) ? req_hi : req_vec;
    assign pick     = req_cand & ~(req_cand - 3'd1);

`ifdef ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             limit_hit;

    assign limit_hit = (state_q == ST_GNT) && (burst_cnt_q == CNT_W'(MAX_BURST));
    assign preempt   = limit_hit && other_req;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if ((state_q != ST_GNT) || release_now || preempt) begin
            burst_cnt_d = '0;
        end else if (limit_hit) begin
            // Nobody else is waiting. Start a fresh window and count this
            // cycle's beat, if there is one.
            burst_cnt_d = beat ? CNT_W'(1) : '0;
        end else if (beat) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign preempt = 1'b0;

    // MAX_BURST only matters when the burst limit is compiled in. Values
    // below 1 are not meaningful.
    if (MAX_BURST < 1) begin : g_max_burst_unsupported
    end
`endif

    // The owner is ready whenever it holds the grant, whatever its req is.
    // The only exception is the cycle in which it is being preempted.
    assign rdy_vec = preempt ? 3'b000 : gnt_q;
    assign beat    = |(rdy_vec & vld_vec);

    assign imap_biu2arb_rdy = rdy_vec[0];
    assign wt_biu2arb_rdy   = rdy_vec[1];
    assign omap_biu2arb_rdy = rdy_vec[2];
    assign arb_gnt          = gnt_q;

    // Next-state logic for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        release_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_d = ST_GNT;
                    gnt_d   = pick;
                end
            end
            ST_GNT: begin
                // A BIU that drops req with a final beat still pending keeps
                // the port until that beat has drained.
                release_now = !owner_req && !owner_vld;
                if (release_now || preempt) begin
                    state_d = ST_IDLE;
                    gnt_d   = 3'b000;
                    rr_d    = {gnt_q[1:0], gnt_q[2]};
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // SRAM command mux. The outputs are zero when there is no beat.
    always_comb begin
        arb2mem_addr  = '0;
        arb2mem_wdata = '0;
        if (beat) begin
            if (gnt_q[0]) begin
                arb2mem_addr = imap_biu2arb_addr;
            end else if (gnt_q[1]) begin
                arb2mem_addr = wt_biu2arb_addr;
            end else begin
                arb2mem_addr  = omap_biu2arb_addr;
                arb2mem_wdata = omap_biu2arb_data;
            end
        end
    end

    assign arb2mem_en = beat;
    assign arb2mem_we = beat & gnt_q[2];

    // Read-return tagging. The tag is captured at the beat, so the returning
    // data does not depend on who owns the port one cycle later.
    assign rd_vld_d    = beat & ~gnt_q[2];
    assign rd_tag_wt_d = beat ? gnt_q[1] : rd_tag_wt_q;

    assign arb2imap_biu_vld  = rd_vld_q & ~rd_tag_wt_q;
    assign arb2wt_biu_vld    = rd_vld_q &  rd_tag_wt_q;
    assign arb2imap_biu_data = arb2imap_biu_vld ? mem2arb_rdata : '0;
    assign arb2wt_biu_data   = arb2wt_biu_vld   ? mem2arb_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            rr_q        <= 3'b001;
            rd_vld_q    <= 1'b0;
            rd_tag_wt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            rd_vld_q    <= rd_vld_d;
            rd_tag_wt_q <= rd_tag_wt_d;
        end
    end

endmodule
